// File: rtl/lsb_if.sv
// Memory request/response bundle between the load/store buffer and the data memory port.
interface lsb_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_done;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        input  mem_done, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
        output mem_done, mem_rdata
    );
endinterface

// File: rtl/lsb.sv
// In-order load/store buffer: circular queue, operand snooping, one memory access at a time.
// Optional macro LSB_IO_GUARD_EN holds I/O-space loads (addr[17:16] == 2'b11) until at ROB head.
module lsb #(
    parameter int unsigned LSB_SIZE_LOG = 3,
    parameter int unsigned ROB_R        = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rob_clear,
    input  logic [ROB_R-1:0] rob_head_id,
    input  logic             is_ls,
    input  logic             ls_store,
    input  logic [2:0]       ls_op,
    input  logic [ROB_R-1:0] ls_rob_id,
    input  logic             rs1_rdy,
    input  logic [31:0]      rs1_val,
    input  logic [ROB_R-1:0] rs1_q,
    input  logic             rs2_rdy,
    input  logic [31:0]      rs2_val,
    input  logic [ROB_R-1:0] rs2_q,
    input  logic [31:0]      imm,
    input  logic             rs_has_output,
    input  logic [ROB_R-1:0] rs_rob_id,
    input  logic [31:0]      rs_output,
    output logic             lsb_full,
    lsb_if.master            mem,
    output logic             lsb_has_output,
    output logic [ROB_R-1:0] lsb_rob_id,
    output logic [31:0]      lsb_output
);
    localparam int unsigned Depth = 2 ** LSB_SIZE_LOG;

    typedef logic [LSB_SIZE_LOG-1:0] ptr_t;
    typedef logic [LSB_SIZE_LOG:0]   cnt_t;
    typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

    typedef struct packed {
        logic             valid;
        logic             store;
        logic [2:0]       op;
        logic [ROB_R-1:0] rob_id;
        logic             rs1_rdy;
        logic [31:0]      rs1_val;
        logic [ROB_R-1:0] rs1_q;
        logic             rs2_rdy;
        logic [31:0]      rs2_val;
        logic [ROB_R-1:0] rs2_q;
        logic [31:0]      imm;
    } entry_t;

    entry_t           ent_q [Depth];
    entry_t           ent_d [Depth];
    entry_t           new_e;
    entry_t           head_e;
    ptr_t             head_q, head_d, tail_q, tail_d;
    cnt_t             count_q, count_d;
    state_e           state_q, state_d;
    logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [1:0]       mem_size_q, mem_size_d;
    logic             cur_load_q, cur_load_d, flushed_q, flushed_d;
    logic [2:0]       cur_op_q, cur_op_d;
    logic [ROB_R-1:0] cur_rob_q, cur_rob_d;
    logic             out_v_q, out_v_d;
    logic [ROB_R-1:0] out_rob_q, out_rob_d;
    logic [31:0]      out_val_q, out_val_d;
    logic [31:0]      head_addr;
    logic             io_ok, launch_ok, dequeue;

    // Resolve one operand against the ALU and LSB broadcast buses.
    function automatic logic [32:0] snoop(input logic rdy, input logic [31:0] val,
                                          input logic [ROB_R-1:0] q,
                                          input logic a_v, input logic [ROB_R-1:0] a_id,
                                          input logic [31:0] a_val,
                                          input logic b_v, input logic [ROB_R-1:0] b_id,
                                          input logic [31:0] b_val);
        logic [32:0] res;
        res = {rdy, val};
        if (!rdy) begin
            if (a_v && q == a_id) begin
                res = {1'b1, a_val};
            end else if (b_v && q == b_id) begin
                res = {1'b1, b_val};
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [31:0] r);
        logic [31:0] res;
        case (op)
            3'b000:  res = {{24{r[7]}}, r[7:0]};
            3'b001:  res = {{16{r[15]}}, r[15:0]};
            3'b100:  res = {24'b0, r[7:0]};
            3'b101:  res = {16'b0, r[15:0]};
            default: res = r;
        endcase
        return res;
    endfunction

    assign head_e    = ent_q[head_q];
    assign head_addr = head_e.rs1_val + head_e.imm;

`ifdef LSB_IO_GUARD_EN
    assign io_ok = (head_addr[17:16] != 2'b11) || (head_e.rob_id == rob_head_id);
`else
    assign io_ok = 1'b1;
`endif

    assign launch_ok = head_e.valid && head_e.rs1_rdy &&
                       (head_e.store ? (head_e.rs2_rdy && head_e.rob_id == rob_head_id) : io_ok);

    always_comb begin
        new_e         = '0;
        new_e.valid   = 1'b1;
        new_e.store   = ls_store;
        new_e.op      = ls_op;
        new_e.rob_id  = ls_rob_id;
        new_e.rs1_q   = rs1_q;
        new_e.rs2_q   = rs2_q;
        new_e.imm     = imm;
        {new_e.rs1_rdy, new_e.rs1_val} = snoop(rs1_rdy, rs1_val, rs1_q,
                                               rs_has_output, rs_rob_id, rs_output,
                                               out_v_q, out_rob_q, out_val_q);
        {new_e.rs2_rdy, new_e.rs2_val} = snoop(rs2_rdy, rs2_val, rs2_q,
                                               rs_has_output, rs_rob_id, rs_output,
                                               out_v_q, out_rob_q, out_val_q);
    end

    always_comb begin
        ent_d       = ent_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;
        cur_load_d  = cur_load_q;
        cur_op_d    = cur_op_q;
        cur_rob_d   = cur_rob_q;
        flushed_d   = flushed_q;
        out_v_d     = out_v_q;
        out_rob_d   = out_rob_q;
        out_val_d   = out_val_q;
        dequeue     = 1'b0;

        if (rdy_in) begin
            out_v_d = 1'b0;
            for (int i = 0; i < Depth; i++) begin
                {ent_d[ptr_t'(i)].rs1_rdy, ent_d[ptr_t'(i)].rs1_val} =
                    snoop(ent_q[ptr_t'(i)].rs1_rdy, ent_q[ptr_t'(i)].rs1_val,
                          ent_q[ptr_t'(i)].rs1_q, rs_has_output, rs_rob_id, rs_output,
                          out_v_q, out_rob_q, out_val_q);
                {ent_d[ptr_t'(i)].rs2_rdy, ent_d[ptr_t'(i)].rs2_val} =
                    snoop(ent_q[ptr_t'(i)].rs2_rdy, ent_q[ptr_t'(i)].rs2_val,
                          ent_q[ptr_t'(i)].rs2_q, rs_has_output, rs_rob_id, rs_output,
                          out_v_q, out_rob_q, out_val_q);
            end

            case (state_q)
                StIdle: begin
                    if (!rob_clear && launch_ok) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = head_e.store;
                        mem_addr_d  = head_addr;
                        mem_wdata_d = head_e.rs2_val;
                        mem_size_d  = head_e.op[1:0];
                        cur_load_d  = !head_e.store;
                        cur_op_d    = head_e.op;
                        cur_rob_d   = head_e.rob_id;
                        flushed_d   = 1'b0;
                        state_d     = StWait;
                    end
                end
                StWait: begin
                    if (mem.mem_done) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        state_d   = StIdle;
                        // A store already flushed from the queue must not pop a newer entry.
                        dequeue   = !flushed_q;
                        if (!(rob_clear && cur_load_q)) begin
                            out_v_d   = 1'b1;
                            out_rob_d = cur_rob_q;
                            out_val_d = cur_load_q ? load_ext(cur_op_q, mem.mem_rdata) : 32'b0;
                        end
                    end else if (rob_clear) begin
                        if (cur_load_q) begin
                            state_d = StDrain;
                        end else begin
                            flushed_d = 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (mem.mem_done) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        state_d   = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (rob_clear) begin
                for (int i = 0; i < Depth; i++) begin
                    ent_d[ptr_t'(i)].valid = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (dequeue) begin
                    ent_d[head_q].valid = 1'b0;
                    head_d = head_q + ptr_t'(1);
                end
                if (is_ls) begin
                    ent_d[tail_q] = new_e;
                    tail_d = tail_q + ptr_t'(1);
                end
                count_d = count_q + cnt_t'(is_ls) - cnt_t'(dequeue);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < Depth; i++) begin
                ent_q[ptr_t'(i)] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_size_q  <= '0;
            cur_load_q  <= 1'b0;
            cur_op_q    <= '0;
            cur_rob_q   <= '0;
            flushed_q   <= 1'b0;
            out_v_q     <= 1'b0;
            out_rob_q   <= '0;
            out_val_q   <= '0;
        end else begin
            ent_q       <= ent_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
            cur_load_q  <= cur_load_d;
            cur_op_q    <= cur_op_d;
            cur_rob_q   <= cur_rob_d;
            flushed_q   <= flushed_d;
            out_v_q     <= out_v_d;
            out_rob_q   <= out_rob_d;
            out_val_q   <= out_val_d;
        end
    end

    assign lsb_full       = count_q >= cnt_t'(Depth - 1);
    assign mem.mem_req    = mem_req_q;
    assign mem.mem_we     = mem_we_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;
    assign mem.mem_size   = mem_size_q;
    assign lsb_has_output = out_v_q;
    assign lsb_rob_id     = out_rob_q;
    assign lsb_output     = out_val_q;
endmodule

// File: doc/lsb.md
LSB -- requirements
Module: lsb

Interface
REQ-001 Parameter: LSB_SIZE_LOG, default 3, log2 of queue depth (8 entries).
REQ-002 clk_in  in  1  single clock; all state updates on rising edge.
REQ-003 rst_in  in  1  reset, asynchronous, active-high.
REQ-004 rdy_in  in  1  global enable; low freezes all state, outputs hold.
REQ-005 rob_clear  in  1  misprediction flush.
REQ-006 rob_head_id  in  ROB_R  ROB entry currently at commit.
REQ-007 is_ls, ls_store, ls_op[2:0], ls_rob_id[ROB_R]  in  issue strobe, store flag, funct3, destination tag.
REQ-008 rs1_rdy, rs1_val[32], rs1_q[ROB_R]; rs2_rdy, rs2_val[32], rs2_q[ROB_R]; imm[32]  in  operands (rs2 is store data).
REQ-009 rs_has_output, rs_rob_id[ROB_R], rs_output[32]  in  ALU broadcast.
REQ-010 lsb_full  out  1  issue must stall.
REQ-011 mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32; mem_size  out  2  memory request.
REQ-012 mem_done  in  1  one-cycle completion pulse; mem_rdata  in  32.
REQ-013 lsb_has_output  out  1; lsb_rob_id  out  ROB_R; lsb_output  out  32  result broadcast to ROB/RS.

Function
REQ-014 Circular FIFO with head, tail, count; entries leave strictly in issue order, only from head.
REQ-015 Issue: when is_ls, write entry at tail, tail+1 wraps modulo 2^LSB_SIZE_LOG; issue and dequeue in the same cycle leave count unchanged.
REQ-016 lsb_full = count >= 2^LSB_SIZE_LOG - 1 (one-slot margin for issue latency).
REQ-017 Snoop: every cycle, each not-ready operand whose tag matches rs_rob_id (rs_has_output) or lsb_rob_id (lsb_has_output) captures that value and becomes ready; same rule applies to operands arriving on the issue port that cycle.
REQ-018 Address = rs1 + imm, 32-bit wrap; mem_size = ls_op[1:0]; mem_wdata = rs2.
REQ-019 FSM states IDLE, WAIT, DRAIN.
REQ-020 IDLE -> WAIT when head entry valid, operands ready, and (load, or store with ls_rob_id == rob_head_id); mem_req/mem_we/mem_addr registered, asserted next cycle.
REQ-021 WAIT: mem_req held high until mem_done; on mem_done dequeue head, drop mem_req, return to IDLE, pulse lsb_has_output for exactly one cycle next cycle.
REQ-022 Load result: LB/LH sign-extend, LBU(100)/LHU(101) zero-extend, LW unchanged; store result = 0.
REQ-023 rob_clear: all entries invalidated, head=tail=count=0 next cycle; if in WAIT with load, go to DRAIN: mem_req held until mem_done, result discarded, then IDLE; no lsb_has_output for flushed ops.
REQ-024 Store in WAIT at rob_clear completes normally (non-speculative, it is at ROB head).
REQ-025 Empty queue: mem_req = 0, FSM stays IDLE.

Reset
REQ-026 rst_in high: head, tail, count = 0; all entries invalid; FSM IDLE; mem_req, mem_we, lsb_has_output, lsb_full = 0; mem_addr, mem_wdata, mem_size, lsb_rob_id, lsb_output = 0.
REQ-027 Reset mid-transaction abandons the request immediately; late mem_done after reset is ignored.

Configuration
REQ-028 Macro LSB_IO_GUARD_EN defined: loads with address[17:16] == 2'b11 (I/O space) also require ls_rob_id == rob_head_id before leaving IDLE.
REQ-029 Macro undefined: loads start as soon as they reach head with operands ready, regardless of address.

Verification
REQ-030 Reset, then issue LW rs1=0x100 ready, imm=4, tag 3; mem_done with rdata 0xDEADBEEF -> mem_addr 0x104, mem_size 2, next cycle lsb_has_output=1, tag 3, output 0xDEADBEEF.
REQ-031 LB with rdata 0x00000080 -> output 0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SW tag 5, rob_head_id=2 -> no mem_req; rob_head_id=5 -> mem_req=1, mem_we=1; done -> output 0, tag 5.
REQ-033 Issue 7 entries without dequeue -> lsb_full=1; one dequeue with simultaneous issue -> count stays 7, lsb_full stays 1.
REQ-034 Load waiting on rs1_q=4; rs_has_output tag 4 value 0x200 -> next eligible cycle mem_addr 0x200+imm.
REQ-035 Load in WAIT, rob_clear pulse -> queue empty, mem_req held to mem_done, no lsb_has_output; with LSB_IO_GUARD_EN, load to 0x30000 not at ROB head -> mem_req stays 0.
